// File: rtl/final_result_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | final_result_mux_if                                                        |
// | Update strobes, hash check and freeze request in; selected result out.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface final_result_mux_if #(
  parameter int SEQ_WIDTH = 64
);
  logic                 hash_check;
  logic [31:0]          hash_in;
  logic                 combo_valid;
  logic [3:0]           combo_out;
  logic                 seq_valid;
  logic [3:0]           seq_out;
  logic                 fin;
  logic                 lvds_data_out;
  logic                 lvds_hitor_out;
  logic                 lvds_chsync_locked_out;
  logic                 lvds_chsync_clk_out;
  logic [SEQ_WIDTH-1:0] last_combo_seqnum;
  logic [SEQ_WIDTH-1:0] last_seq_seqnum;
  logic                 hash_ok;
  logic                 hash_err;
  logic                 final_done;

  modport master (
    output hash_check, hash_in, combo_valid, combo_out, seq_valid, seq_out, fin,
    input  lvds_data_out, lvds_hitor_out, lvds_chsync_locked_out, lvds_chsync_clk_out,
    input  last_combo_seqnum, last_seq_seqnum, hash_ok, hash_err, final_done
  );

  modport slave (
    input  hash_check, hash_in, combo_valid, combo_out, seq_valid, seq_out, fin,
    output lvds_data_out, lvds_hitor_out, lvds_chsync_locked_out, lvds_chsync_clk_out,
    output last_combo_seqnum, last_seq_seqnum, hash_ok, hash_err, final_done
  );
endinterface
`default_nettype wire

// File: rtl/final_result_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | final_result_mux                                                           |
// | Tags combo/seq result updates, drives the most recent one, hash/freeze.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module final_result_mux #(
  parameter logic [31:0] PROTECTLIB_HASH = 32'd1563611712,
  parameter int          SEQ_WIDTH       = 64
) (
  input  logic              clk,
  input  logic              rst,
  final_result_mux_if.slave bus
);

  localparam logic [SEQ_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [SEQ_WIDTH-1:0] CNT_START = SEQ_WIDTH'(1);

  logic [SEQ_WIDTH-1:0] cnt;
  logic [SEQ_WIDTH-1:0] combo_tag;
  logic [SEQ_WIDTH-1:0] seq_tag;
  logic [3:0]           combo_r;
  logic [3:0]           seq_r;
  logic                 hash_ok;
  logic                 hash_err;
  logic                 final_done;

  logic [SEQ_WIDTH-1:0] cnt_p1;
  logic [SEQ_WIDTH-1:0] cnt_p2;
  logic [3:0]           sel;

  // Saturating increments: once the counter pins at all-ones both sources
  // receive identical tags and the tie rule hands the outputs to combo.
  always_comb begin
    cnt_p1 = (cnt == CNT_MAX)    ? cnt    : cnt + CNT_START;
    cnt_p2 = (cnt_p1 == CNT_MAX) ? cnt_p1 : cnt_p1 + CNT_START;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= CNT_START;
      combo_tag  <= '0;
      seq_tag    <= '0;
      combo_r    <= '0;
      seq_r      <= '0;
      hash_ok    <= 1'b0;
      hash_err   <= 1'b0;
      final_done <= 1'b0;
    end else if (!final_done) begin
      if (bus.hash_check) begin
        if (bus.hash_in == PROTECTLIB_HASH) begin
          hash_ok <= 1'b1;
        end else begin
          hash_err <= 1'b1;
        end
      end
      if (bus.fin) begin
        final_done <= 1'b1;
      end else begin
        case ({bus.combo_valid, bus.seq_valid})
          2'b10: begin
            combo_r   <= bus.combo_out;
            combo_tag <= cnt;
            cnt       <= cnt_p1;
          end
          2'b01: begin
            seq_r   <= bus.seq_out;
            seq_tag <= cnt;
            cnt     <= cnt_p1;
          end
          2'b11: begin
            combo_r   <= bus.combo_out;
            combo_tag <= cnt;
            seq_r     <= bus.seq_out;
            seq_tag   <= cnt_p1;
            cnt       <= cnt_p2;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Strictly newer sequential tag wins; ties (incl. post-reset) go to combo.
  always_comb begin
    sel = (seq_tag > combo_tag) ? seq_r : combo_r;
  end

  assign bus.lvds_data_out          = sel[0];
  assign bus.lvds_hitor_out         = sel[1];
  assign bus.lvds_chsync_locked_out = sel[2];
  assign bus.lvds_chsync_clk_out    = sel[3];
  assign bus.last_combo_seqnum      = combo_tag;
  assign bus.last_seq_seqnum        = seq_tag;
  assign bus.hash_ok                = hash_ok;
  assign bus.hash_err               = hash_err;
  assign bus.final_done             = final_done;

endmodule
`default_nettype wire

// File: tb/tb_final_result_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_final_result_mux                                                        |
// | Directed plus random checks of a 64-bit and a 3-bit (saturating) instance. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_final_result_mux;

  localparam logic [31:0] HASH = 32'd1563611712;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  final_result_mux_if #(.SEQ_WIDTH(64)) bus_w ();
  final_result_mux_if #(.SEQ_WIDTH(3))  bus_n ();

  final_result_mux #(.PROTECTLIB_HASH(HASH), .SEQ_WIDTH(64)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  final_result_mux #(.PROTECTLIB_HASH(HASH), .SEQ_WIDTH(3)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  // Reference model: index 0 = 64-bit instance, index 1 = 3-bit instance.
  logic [63:0] m_cnt  [2];
  logic [63:0] m_ctag [2];
  logic [63:0] m_stag [2];
  logic [63:0] m_max  [2];
  logic [3:0]  m_cr   [2];
  logic [3:0]  m_sr   [2];
  logic        m_ok, m_err, m_done;

  function automatic logic [63:0] sat_add(logic [63:0] x, logic [63:0] n, logic [63:0] mx);
    if (mx - x < n) return mx;
    return x + n;
  endfunction

  function automatic logic [3:0] exp_vec(int k);
    return (m_stag[k] > m_ctag[k]) ? m_sr[k] : m_cr[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 64'd1; m_ctag[k] = '0; m_stag[k] = '0; m_cr[k] = '0; m_sr[k] = '0;
    end
    m_ok = 1'b0; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic cv, input logic [3:0] co, input logic sv,
                            input logic [3:0] so, input logic hc, input logic [31:0] hi,
                            input logic f, input logic r);
    if (r) begin
      model_reset();
    end else if (!m_done) begin
      if (hc) begin
        if (hi == HASH) m_ok = 1'b1; else m_err = 1'b1;
      end
      if (f) begin
        m_done = 1'b1;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (cv) begin
            m_cr[k] = co; m_ctag[k] = m_cnt[k];
            m_cnt[k] = sat_add(m_cnt[k], 64'd1, m_max[k]);
          end
          if (sv) begin
            m_sr[k] = so; m_stag[k] = m_cnt[k];
            m_cnt[k] = sat_add(m_cnt[k], 64'd1, m_max[k]);
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vec_w();
    return {bus_w.lvds_chsync_clk_out, bus_w.lvds_chsync_locked_out,
            bus_w.lvds_hitor_out, bus_w.lvds_data_out};
  endfunction

  function automatic logic [3:0] vec_n();
    return {bus_n.lvds_chsync_clk_out, bus_n.lvds_chsync_locked_out,
            bus_n.lvds_hitor_out, bus_n.lvds_data_out};
  endfunction

  task automatic check_all();
    check("w_vec",   64'(vec_w()),                 64'(exp_vec(0)));
    check("w_ctag",  bus_w.last_combo_seqnum,      m_ctag[0]);
    check("w_stag",  bus_w.last_seq_seqnum,        m_stag[0]);
    check("w_flags", 64'({bus_w.hash_ok, bus_w.hash_err, bus_w.final_done}),
                     64'({m_ok, m_err, m_done}));
    check("n_vec",   64'(vec_n()),                 64'(exp_vec(1)));
    check("n_ctag",  64'(bus_n.last_combo_seqnum), m_ctag[1]);
    check("n_stag",  64'(bus_n.last_seq_seqnum),   m_stag[1]);
    check("n_flags", 64'({bus_n.hash_ok, bus_n.hash_err, bus_n.final_done}),
                     64'({m_ok, m_err, m_done}));
  endtask

  task automatic drive(input logic cv, input logic [3:0] co, input logic sv,
                       input logic [3:0] so, input logic hc, input logic [31:0] hi,
                       input logic f, input logic r);
    bus_w.combo_valid = cv; bus_w.combo_out = co; bus_w.seq_valid = sv; bus_w.seq_out = so;
    bus_w.hash_check = hc;  bus_w.hash_in = hi;   bus_w.fin = f;
    bus_n.combo_valid = cv; bus_n.combo_out = co; bus_n.seq_valid = sv; bus_n.seq_out = so;
    bus_n.hash_check = hc;  bus_n.hash_in = hi;   bus_n.fin = f;
    rst = r;
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, then
  // return idle inputs and compare against the model at the next falling edge.
  task automatic cycle(input logic cv, input logic [3:0] co, input logic sv,
                       input logic [3:0] so, input logic hc, input logic [31:0] hi,
                       input logic f, input logic r);
    drive(cv, co, sv, so, hc, hi, f, r);
    @(posedge clk);
    model_step(cv, co, sv, so, hc, hi, f, r);
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_all();
  endtask

  initial begin
    m_max[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_max[1] = 64'd7;
    model_reset();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_all();
    check("rst_vec", 64'(vec_w()), 64'h0);
    check("rst_done", 64'(bus_w.final_done), 64'h0);

    cycle(1'b1, 4'b0101, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dir_combo1_vec", 64'(vec_w()), 64'h5);
    check("dir_combo1_tag", bus_w.last_combo_seqnum, 64'd1);

    cycle(1'b0, 4'h0, 1'b1, 4'b1010, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dir_seq2_vec", 64'(vec_w()), 64'hA);
    check("dir_seq2_tag", bus_w.last_seq_seqnum, 64'd2);

    cycle(1'b1, 4'b0011, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dir_combo3_vec", 64'(vec_w()), 64'h3);
    check("dir_combo3_tag", bus_w.last_combo_seqnum, 64'd3);

    cycle(1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dir_both_vec", 64'(vec_w()), 64'h0);
    check("dir_both_ctag", bus_w.last_combo_seqnum, 64'd4);
    check("dir_both_stag", bus_w.last_seq_seqnum, 64'd5);

    cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, HASH, 1'b0, 1'b0);
    check("dir_hash_good", 64'({bus_w.hash_ok, bus_w.hash_err}), 64'b10);
    cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    check("dir_hash_bad", 64'({bus_w.hash_ok, bus_w.hash_err}), 64'b11);

    cycle(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    check("dir_final_done", 64'(bus_w.final_done), 64'h1);
    check("dir_final_vec", 64'(vec_w()), 64'h0);
    cycle(1'b1, 4'h9, 1'b1, 4'h6, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dir_frozen_stag", bus_w.last_seq_seqnum, 64'd5);
    check("dir_frozen_vec", 64'(vec_w()), 64'h0);

    cycle(1'b1, 4'h7, 1'b1, 4'h8, 1'b1, 32'h1, 1'b1, 1'b1);
    check("dir_rst_vec", 64'(vec_w()), 64'h0);
    check("dir_rst_done", 64'(bus_w.final_done), 64'h0);

    for (int i = 0; i < 600; i++) begin
      logic        hc, f, r;
      logic [31:0] hi;
      hc = ($urandom_range(0, 7) == 0);
      hi = ($urandom_range(0, 1) == 0) ? HASH : $urandom;
      f  = ($urandom_range(0, 59) == 0);
      r  = ($urandom_range(0, 39) == 0);
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
            4'($urandom), hc, hi, f, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
